// File: rtl/alu_serial_seq.sv
// ---------------------------------------------------------------------------
// alu_serial_seq -- bit-serial sequencer for a combinational 1-bit ALU slice
//
// An N-bit operand pair and a 2-bit op are accepted through a valid/ready
// handshake. The sequencer then presents one bit per cycle to the slice,
// LSB first, and feeds the slice carry back in on the following bit. The
// slice sum bits are collected into an N-bit result. The result is offered
// through a second valid/ready handshake.
//
// This file also holds alu1bit, the combinational slice that sits on the
// other side of the slice_* ports.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready   request handshake; a_in, b_in and op_in are
//                         captured when both are high
//   a_in, b_in [N-1:0]    operands
//   op_in [1:0]           00 NOR, 01 XOR, 10 ADD, 11 SUB (A-B)
//   slice_a, slice_b      current operand bits to the slice
//   slice_cin, slice_op   carry-in and op to the slice
//   slice_s, slice_cout   combinational sum and carry back from the slice
//   out_valid / out_ready result handshake
//   result [N-1:0]        operation result, modulo 2^N
//   carry                 ADD: carry-out; SUB: 1 = no borrow; NOR/XOR: 0
//   zero                  result == 0
// ---------------------------------------------------------------------------
module alu_serial_seq #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a_in,
  input  logic [N-1:0] b_in,
  input  logic [1:0]   op_in,
  output logic         slice_a,
  output logic         slice_b,
  output logic         slice_cin,
  output logic [1:0]   slice_op,
  input  logic         slice_s,
  input  logic         slice_cout,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic         carry,
  output logic         zero
);

  localparam int CW = (N > 2) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  localparam logic [1:0] OP_SUB = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg;
  logic [N-1:0]    a_sh_reg, b_sh_reg, res_sh_reg;
  logic [N-1:0]    res_next;
  logic [1:0]      op_reg;
  logic            carry_reg;
  logic            carry_next;
  logic            last_bit;

  // The newest sum bit enters at the MSB; after N shifts the first (LSB)
  // sum bit has arrived at bit 0.
  assign res_next   = {slice_s, res_sh_reg[N-1:1]};
  // Logic ops never propagate a carry, so the slice cout is only trusted
  // for the arithmetic ops.
  assign carry_next = op_reg[1] ? slice_cout : 1'b0;
  assign last_bit   = (cnt_reg == LAST);

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next state and handshake / slice outputs
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    slice_a    = 1'b0;
    slice_b    = 1'b0;
    slice_cin  = 1'b0;
    slice_op   = 2'b00;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_next = RUN;
        end
      end
      RUN: begin
        slice_a   = a_sh_reg[0];
        slice_b   = b_sh_reg[0];
        slice_cin = carry_reg;
        slice_op  = op_reg;
        if (last_bit) begin
          state_next = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        // Returning to IDLE here means in_ready only rises the cycle after
        // the result handshake.
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath: operand/result shift registers, carry feedback, outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_reg   <= '0;
      b_sh_reg   <= '0;
      res_sh_reg <= '0;
      op_reg     <= 2'b00;
      carry_reg  <= 1'b0;
      cnt_reg    <= '0;
      result     <= '0;
      carry      <= 1'b0;
      zero       <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            a_sh_reg  <= a_in;
            b_sh_reg  <= b_in;
            op_reg    <= op_in;
            cnt_reg   <= '0;
            // SUB is A + ~B + 1: the slice inverts B, we supply the +1.
            carry_reg <= (op_in == OP_SUB);
          end
        end
        RUN: begin
          res_sh_reg <= res_next;
          a_sh_reg   <= a_sh_reg >> 1;
          b_sh_reg   <= b_sh_reg >> 1;
          carry_reg  <= carry_next;
          cnt_reg    <= cnt_reg + 1'b1;
          if (last_bit) begin
            result <= res_next;
            carry  <= carry_next;
            zero   <= (res_next == '0);
          end
        end
        default: begin
          // DONE: everything holds until the consumer takes the result.
        end
      endcase
    end
  end

endmodule

// ---------------------------------------------------------------------------
// alu1bit -- combinational 1-bit ALU slice
//
// Ports
//   a, b     operand bits
//   cin      carry in
//   op [1:0] 00 NOR, 01 XOR, 10 ADD, 11 SUB (B inverted internally)
//   s        result bit
//   cout     carry out (0 for the logic ops)
// ---------------------------------------------------------------------------
module alu1bit (
  input  logic       a,
  input  logic       b,
  input  logic       cin,
  input  logic [1:0] op,
  output logic       s,
  output logic       cout
);

  logic b_eff;

  // op[0] selects B inversion for the arithmetic ops (ADD vs SUB).
  assign b_eff = b ^ op[0];

  always_comb begin
    s    = 1'b0;
    cout = 1'b0;
    case (op)
      2'b00: s = ~(a | b);
      2'b01: s = a ^ b;
      default: begin
        s    = a ^ b_eff ^ cin;
        cout = (a & b_eff) | (cin & (a ^ b_eff));
      end
    endcase
  end

endmodule

// File: tb/tb_alu_serial_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_serial_seq -- self-checking bench for alu_serial_seq + alu1bit, N=8.
// Expected results come from a reference model, are pushed to a scoreboard
// queue when a request is accepted and popped when the result handshake
// completes.
// ---------------------------------------------------------------------------
module tb_alu_serial_seq;

  localparam int N = 8;
  localparam logic [1:0] OP_NOR = 2'b00;
  localparam logic [1:0] OP_XOR = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_SUB = 2'b11;

  typedef struct packed {
    logic [N-1:0] res;
    logic         cy;
    logic         zf;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a_in;
  logic [N-1:0] b_in;
  logic [1:0]   op_in;
  logic         slice_a;
  logic         slice_b;
  logic         slice_cin;
  logic [1:0]   slice_op;
  logic         slice_s;
  logic         slice_cout;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] result;
  logic         carry;
  logic         zero;

  int   checks   = 0;
  int   failures = 0;
  exp_t sb_q[$];

  alu_serial_seq #(.N(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a_in       (a_in),
    .b_in       (b_in),
    .op_in      (op_in),
    .slice_a    (slice_a),
    .slice_b    (slice_b),
    .slice_cin  (slice_cin),
    .slice_op   (slice_op),
    .slice_s    (slice_s),
    .slice_cout (slice_cout),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .carry      (carry),
    .zero       (zero)
  );

  alu1bit slice (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (slice_cin),
    .op   (slice_op),
    .s    (slice_s),
    .cout (slice_cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on the full words.
  function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b,
                                 input logic [1:0] op);
    exp_t       e;
    logic [N:0] w;
    w = '0;
    case (op)
      OP_NOR: w = {1'b0, ~(a | b)};
      OP_XOR: w = {1'b0, a ^ b};
      OP_ADD: w = {1'b0, a} + {1'b0, b};
      default: w = {1'b0, a} + {1'b0, ~b} + 1;
    endcase
    e.res = w[N-1:0];
    e.cy  = w[N];
    e.zf  = (w[N-1:0] == '0);
    return e;
  endfunction

  // Wait for in_ready, present the request and return just after the
  // accepting edge. The expected result is pushed at acceptance.
  task automatic start_op(input string tag, input logic [N-1:0] a,
                          input logic [N-1:0] b, input logic [1:0] op);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    a_in     = a;
    b_in     = b;
    op_in    = op;
    in_valid = 1'b1;
    sb_q.push_back(model(a, b, op));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a_in     = ~a;   // later input changes must not matter
    b_in     = ~b;
    op_in    = ~op;
    check({tag, "_cin0"}, 32'(slice_cin), 32'(op == OP_SUB));
    check({tag, "_slice_op"}, 32'(slice_op), 32'(op));
  endtask

  // Count edges from acceptance until out_valid; latency must be N.
  task automatic wait_out(input string tag);
    int lat;
    lat = 0;
    while (lat < 40) begin
      @(posedge clk);
      lat++;
      #1;
      if (out_valid) break;
    end
    check({tag, "_latency"}, 32'(lat), 32'(N));
  endtask

  // Compare against the scoreboard and complete the result handshake.
  task automatic finish_op(input string tag);
    exp_t e;
    @(negedge clk);
    if (sb_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s_scoreboard observed=empty expected=entry", tag);
      return;
    end
    e = sb_q.pop_front();
    check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_result"}, 32'(result), 32'(e.res));
    check({tag, "_carry"}, 32'(carry), 32'(e.cy));
    check({tag, "_zero"}, 32'(zero), 32'(e.zf));
    $display("op %s: result=%h carry=%0d zero=%0d (expected %h %0d %0d)",
             tag, result, carry, zero, e.res, e.cy, e.zf);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_drop_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_ready_after"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    exp_t e5;
    int   stray;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a_in      = '0;
    b_in      = '0;
    op_in     = 2'b00;

    // Reset state
    #2;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_flags", {30'd0, carry, zero}, 32'd0);
    check("rst_slice", {27'd0, slice_a, slice_b, slice_cin, slice_op}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed operations
    start_op("add_7f_01", 8'h7F, 8'h01, OP_ADD); wait_out("add_7f_01"); finish_op("add_7f_01");
    start_op("add_ff_01", 8'hFF, 8'h01, OP_ADD); wait_out("add_ff_01"); finish_op("add_ff_01");
    start_op("sub_05_07", 8'h05, 8'h07, OP_SUB); wait_out("sub_05_07"); finish_op("sub_05_07");
    start_op("sub_07_05", 8'h07, 8'h05, OP_SUB); wait_out("sub_07_05"); finish_op("sub_07_05");
    start_op("nor_f0_0f", 8'hF0, 8'h0F, OP_NOR); wait_out("nor_f0_0f"); finish_op("nor_f0_0f");
    start_op("xor_aa_ff", 8'hAA, 8'hFF, OP_XOR); wait_out("xor_aa_ff"); finish_op("xor_aa_ff");
    start_op("sub_33_33", 8'h33, 8'h33, OP_SUB); wait_out("sub_33_33"); finish_op("sub_33_33");

    // A few random operations
    for (int i = 0; i < 6; i++) begin
      logic [N-1:0] ra, rb;
      logic [1:0]   ro;
      ra = N'($urandom);
      rb = N'($urandom);
      ro = 2'($urandom_range(0, 3));
      start_op("rand", ra, rb, ro); wait_out("rand"); finish_op("rand");
    end

    // Back-pressure in DONE with a competing request held
    start_op("hold", 8'h3C, 8'h11, OP_ADD);
    wait_out("hold");
    e5 = sb_q[0];
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      a_in     = 8'h22;
      b_in     = 8'h33;
      op_in    = OP_XOR;
      in_valid = 1'b1;
      check("hold_out_valid", 32'(out_valid), 32'd1);
      check("hold_result", 32'(result), 32'(e5.res));
      check("hold_in_ready", 32'(in_ready), 32'd0);
    end
    finish_op("hold");
    // in_valid is still high, so the held request is accepted on this edge
    sb_q.push_back(model(8'h22, 8'h33, OP_XOR));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("next_accepted", 32'(in_ready), 32'd0);
    wait_out("next");
    finish_op("next");

    // Reset in the middle of RUN (cnt == 3)
    start_op("abort", 8'h12, 8'h34, OP_ADD);
    repeat (3) @(posedge clk);
    #1;
    check("abort_running", 32'(in_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_result", 32'(result), 32'd0);
    check("abort_flags", {30'd0, carry, zero}, 32'd0);
    check("abort_slice", {27'd0, slice_a, slice_b, slice_cin, slice_op}, 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    stray = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (out_valid) stray++;
    end
    check("abort_no_stray", 32'(stray), 32'd0);
    check("abort_ready_after", 32'(in_ready), 32'd1);

    // Recovery after reset
    start_op("post_rst", 8'h80, 8'h80, OP_ADD); wait_out("post_rst"); finish_op("post_rst");

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
